// File: rtl/alu_cmp_iter.sv
// Iterative magnitude/equality comparator: walks the operands one slice per cycle,
// MSB slice first, and stops at the first slice that differs.
//
// state | meaning
// IDLE  | waiting for i_start; result outputs hold the last result
// RUN   | comparing slice idx_q of the latched operands
// DONE  | result registered, o_valid high for this one cycle
module alu_cmp_iter #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_unsigned,
  output logic             o_busy,
  output logic             o_valid,
  output logic             o_lt,
  output logic             o_eq
);

  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             lt_q;
  logic             eq_q;
  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;

  assign a_slice = a_q[idx_q*SLICE +: SLICE];
  assign b_slice = b_q[idx_q*SLICE +: SLICE];

  // Signed compare is done as unsigned after flipping the sign bits at latch time.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            a_q     <= i_unsigned ? i_a : (i_a ^ MSB_MASK);
            b_q     <= i_unsigned ? i_b : (i_b ^ MSB_MASK);
            idx_q   <= IDXW'(N - 1);
            state_q <= RUN;
          end
        end
        RUN: begin
          if (a_slice != b_slice) begin
            lt_q    <= (a_slice < b_slice);
            eq_q    <= 1'b0;
            state_q <= DONE;
          end else if (idx_q == '0) begin
            lt_q    <= 1'b0;
            eq_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - IDXW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_busy  = (state_q != IDLE);
  assign o_valid = (state_q == DONE);
  assign o_lt    = lt_q;
  assign o_eq    = eq_q;

endmodule

// File: tb/tb_alu_cmp_iter.sv
// Directed bench for alu_cmp_iter: 32/8 main instance plus 64/16 and 8/8 instances.
module tb_alu_cmp_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        uns;
  logic        busy, valid, lt, eq;

  logic        start64, uns64;
  logic [63:0] a64, b64;
  logic        busy64, valid64, lt64, eq64;

  logic        start8, uns8;
  logic [7:0]  a8, b8;
  logic        busy8, valid8, lt8, eq8;

  int pass_cnt;
  int total_cnt;

  alu_cmp_iter #(.WIDTH(32), .SLICE(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
    .i_unsigned(uns), .o_busy(busy), .o_valid(valid), .o_lt(lt), .o_eq(eq)
  );

  alu_cmp_iter #(.WIDTH(64), .SLICE(16)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start64), .i_a(a64), .i_b(b64),
    .i_unsigned(uns64), .o_busy(busy64), .o_valid(valid64), .o_lt(lt64), .o_eq(eq64)
  );

  alu_cmp_iter #(.WIDTH(8), .SLICE(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_a(a8), .i_b(b8),
    .i_unsigned(uns8), .o_busy(busy8), .o_valid(valid8), .o_lt(lt8), .o_eq(eq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch one 32-bit compare; scramble inputs right after the accept edge.
  task automatic run32(input logic [31:0] ta, input logic [31:0] tb_v, input logic tu,
                       output logic olt, output logic oeq, output int om, output int obusy);
    olt = 1'bx;
    oeq = 1'bx;
    om  = 0;
    @(negedge clk);
    a = ta; b = tb_v; uns = tu; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~ta; b = ~tb_v; uns = ~tu;
    obusy = busy ? 1 : 0;
    for (int i = 1; i <= 8 && om == 0; i++) begin
      @(posedge clk);
      #1;
      if (busy) obusy++;
      if (valid) begin
        om  = i;
        olt = lt;
        oeq = eq;
      end
    end
    for (int i = 0; i < 4 && busy; i++) begin
      @(posedge clk);
      #1;
      if (busy) obusy++;
    end
  endtask

  task automatic test_reset();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid); else pass_cnt++;
    total_cnt++; if (lt !== 1'b0) $display("FAIL reset_lt got=%b exp=0", lt); else pass_cnt++;
    total_cnt++; if (eq !== 1'b0) $display("FAIL reset_eq got=%b exp=0", eq); else pass_cnt++;
  endtask

  task automatic test_signed_neg();
    logic olt, oeq; int om, ob;
    run32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, olt, oeq, om, ob);
    total_cnt++; if (olt !== 1'b1) $display("FAIL sneg_lt got=%b exp=1", olt); else pass_cnt++;
    total_cnt++; if (oeq !== 1'b0) $display("FAIL sneg_eq got=%b exp=0", oeq); else pass_cnt++;
    total_cnt++; if (om != 1) $display("FAIL sneg_latency got=%0d exp=1", om); else pass_cnt++;
    total_cnt++; if (valid !== 1'b0) $display("FAIL sneg_valid_pulse got=%b exp=0", valid); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (lt !== 1'b1) $display("FAIL sneg_lt_hold got=%b exp=1", lt); else pass_cnt++;
  endtask

  task automatic test_unsigned_ff();
    logic olt, oeq; int om, ob;
    run32(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, olt, oeq, om, ob);
    total_cnt++; if (olt !== 1'b0) $display("FAIL uff_lt got=%b exp=0", olt); else pass_cnt++;
    total_cnt++; if (oeq !== 1'b0) $display("FAIL uff_eq got=%b exp=0", oeq); else pass_cnt++;
    total_cnt++; if (om != 1) $display("FAIL uff_latency got=%0d exp=1", om); else pass_cnt++;
  endtask

  task automatic test_equal();
    logic olt, oeq; int om, ob;
    run32(32'h1234_5678, 32'h1234_5678, 1'b0, olt, oeq, om, ob);
    total_cnt++; if (oeq !== 1'b1) $display("FAIL equal_eq got=%b exp=1", oeq); else pass_cnt++;
    total_cnt++; if (olt !== 1'b0) $display("FAIL equal_lt got=%b exp=0", olt); else pass_cnt++;
    total_cnt++; if (om != 4) $display("FAIL equal_latency got=%0d exp=4", om); else pass_cnt++;
    total_cnt++; if (ob != 5) $display("FAIL equal_busy_cycles got=%0d exp=5", ob); else pass_cnt++;
  endtask

  task automatic test_boundaries();
    logic olt, oeq; int om, ob;
    run32(32'h0000_0001, 32'h0000_0002, 1'b1, olt, oeq, om, ob);
    total_cnt++; if (olt !== 1'b1) $display("FAIL u1v2_lt got=%b exp=1", olt); else pass_cnt++;
    total_cnt++; if (om != 4) $display("FAIL u1v2_latency got=%0d exp=4", om); else pass_cnt++;
    run32(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, olt, oeq, om, ob);
    total_cnt++; if (olt !== 1'b1) $display("FAIL sminmax_lt got=%b exp=1", olt); else pass_cnt++;
    total_cnt++; if (om != 1) $display("FAIL sminmax_latency got=%0d exp=1", om); else pass_cnt++;
    run32(32'h0000_0100, 32'h0000_00FF, 1'b1, olt, oeq, om, ob);
    total_cnt++; if (olt !== 1'b0) $display("FAIL u100_lt got=%b exp=0", olt); else pass_cnt++;
    total_cnt++; if (om != 3) $display("FAIL u100_latency got=%0d exp=3", om); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int nvalid; logic lt_seen; logic prev_valid;
    nvalid = 0; lt_seen = 1'bx; prev_valid = 1'b0;
    @(negedge clk);
    a = 32'd5; b = 32'd3; uns = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd1; b = 32'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (prev_valid) start = 1'b0;
      prev_valid = valid;
      if (valid) begin
        nvalid++;
        lt_seen = lt;
      end
    end
    start = 1'b0;
    total_cnt++; if (nvalid != 1) $display("FAIL b2b_valid_count got=%0d exp=1", nvalid); else pass_cnt++;
    total_cnt++; if (lt_seen !== 1'b0) $display("FAIL b2b_lt got=%b exp=0", lt_seen); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_busy_end got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    logic olt, oeq; int om, ob; logic saw_valid;
    run32(32'h0000_0055, 32'h0000_0055, 1'b1, olt, oeq, om, ob);
    total_cnt++; if (eq !== 1'b1) $display("FAIL rst_pre_eq got=%b exp=1", eq); else pass_cnt++;
    @(negedge clk);
    a = 32'd1; b = 32'd2; uns = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (valid !== 1'b0) $display("FAIL rst_mid_valid got=%b exp=0", valid); else pass_cnt++;
    total_cnt++; if (lt !== 1'b0) $display("FAIL rst_mid_lt got=%b exp=0", lt); else pass_cnt++;
    total_cnt++; if (eq !== 1'b0) $display("FAIL rst_mid_eq got=%b exp=0", eq); else pass_cnt++;
    saw_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (valid) saw_valid = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (valid) saw_valid = 1'b1;
    end
    total_cnt++; if (saw_valid !== 1'b0) $display("FAIL rst_no_valid got=%b exp=0", saw_valid); else pass_cnt++;
    run32(32'h0001_0000, 32'h0000_FFFF, 1'b1, olt, oeq, om, ob);
    total_cnt++; if (om != 2) $display("FAIL rst_after_latency got=%0d exp=2", om); else pass_cnt++;
    total_cnt++; if (olt !== 1'b0) $display("FAIL rst_after_lt got=%b exp=0", olt); else pass_cnt++;
    total_cnt++; if (oeq !== 1'b0) $display("FAIL rst_after_eq got=%b exp=0", oeq); else pass_cnt++;
  endtask

  task automatic test_widths();
    int om; logic olt;
    om = 0; olt = 1'bx;
    @(negedge clk);
    a64 = 64'h0; b64 = 64'h1; uns64 = 1'b1; start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    for (int i = 1; i <= 8 && om == 0; i++) begin
      @(posedge clk); #1;
      if (valid64) begin om = i; olt = lt64; end
    end
    total_cnt++; if (olt !== 1'b1) $display("FAIL w64_lt got=%b exp=1", olt); else pass_cnt++;
    total_cnt++; if (om != 4) $display("FAIL w64_latency got=%0d exp=4", om); else pass_cnt++;
    om = 0; olt = 1'bx;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h00; uns8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 1; i <= 8 && om == 0; i++) begin
      @(posedge clk); #1;
      if (valid8) begin om = i; olt = lt8; end
    end
    total_cnt++; if (olt !== 1'b1) $display("FAIL w8_lt got=%b exp=1", olt); else pass_cnt++;
    total_cnt++; if (om != 1) $display("FAIL w8_latency got=%0d exp=1", om); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; uns = 1'b0;
    start64 = 1'b0; a64 = '0; b64 = '0; uns64 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; uns8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_signed_neg();
    test_unsigned_ff();
    test_equal();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_run();
    test_widths();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_cmp_iter.md
ALU_CMP_ITER -- requirements
Module: alu_cmp_iter

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits.
REQ-002 Parameter SLICE, default 8: bits compared per cycle; WIDTH SHALL be an integer multiple of SLICE; N = WIDTH/SLICE.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 i_clk  input  1  clock, all state updates on rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_start  input  1  request a compare; accepted only when o_busy=0.
REQ-007 i_a  input  WIDTH  operand A, sampled on accept edge.
REQ-008 i_b  input  WIDTH  operand B, sampled on accept edge.
REQ-009 i_unsigned  input  1  1 = unsigned (SLTU), 0 = two's-complement signed (SLT); sampled on accept edge.
REQ-010 o_busy  output  1  high in RUN and DONE states.
REQ-011 o_valid  output  1  one-cycle pulse, result available.
REQ-012 o_lt  output  1  1 when A < B under the sampled mode.
REQ-013 o_eq  output  1  1 when A == B.

Function
REQ-014 States SHALL be IDLE, RUN, DONE; o_busy = (state != IDLE); o_valid = (state == DONE).
REQ-015 IDLE: on edge with i_start=1 -> RUN; latch operands, slice index idx = N-1.
REQ-016 Signed mode: bit WIDTH-1 of both latched operands SHALL be inverted at latch time; comparison thereafter is unsigned on the adjusted values.
REQ-017 RUN: each cycle compare slice [idx*SLICE +: SLICE] of A and B, MSB slice first.
REQ-018 RUN, slices differ: register o_lt = (A slice < B slice), o_eq = 0, -> DONE (early termination).
REQ-019 RUN, slices equal, idx = 0: register o_lt = 0, o_eq = 1, -> DONE.
REQ-020 RUN, slices equal, idx > 0: idx decrements, stay in RUN.
REQ-021 DONE: unconditionally -> IDLE on next edge; o_valid high exactly one cycle.
REQ-022 Latency: if start accepted at edge k and the m-th examined slice (1 <= m <= N) resolves, o_valid SHALL be high in the cycle after edge k+m; o_busy returns low after edge k+m+1.
REQ-023 o_lt/o_eq SHALL hold their value from DONE until the next result is registered; they SHALL not change during IDLE or while RUN continues without resolution.
REQ-024 i_start in RUN or DONE SHALL be ignored (no queueing); i_a/i_b/i_unsigned changes after the accept edge SHALL not affect the in-flight result.
REQ-025 Start in the same cycle as o_valid (state DONE) SHALL be ignored; a new start is accepted earliest in the cycle after o_valid.
REQ-026 o_lt and o_eq SHALL never both be 1.

Reset
REQ-027 i_rst_n low SHALL immediately (asynchronously) force state IDLE, idx = 0, operand registers 0, o_busy = 0, o_valid = 0, o_lt = 0, o_eq = 0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no o_valid pulse; first start after deassertion SHALL be accepted normally.

Verification
REQ-029 WIDTH=32, SLICE=8, signed: A=0xFFFFFFFF, B=0x00000001 -> o_lt=1, o_eq=0, o_valid one cycle after accept edge+1 (m=1).
REQ-030 Same operands, unsigned -> o_lt=0, o_eq=0, m=1.
REQ-031 A=B=0x12345678, signed -> o_eq=1, o_lt=0, m=4; o_busy high for 5 cycles.
REQ-032 Unsigned A=0x00000001, B=0x00000002 -> o_lt=1, m=4; signed A=0x80000000, B=0x7FFFFFFF -> o_lt=1, m=1.
REQ-033 Start with A=5,B=3 then pulse i_start with A=1,B=9 while busy and in DONE -> only one o_valid, o_lt=0; reset asserted during RUN -> all outputs 0 immediately, no o_valid.
REQ-034 WIDTH=64, SLICE=16: A=0x0000000000000000, B=0x0000000000000001 unsigned -> o_lt=1, m=4; WIDTH=8, SLICE=8: A=0x80, B=0x00 signed -> o_lt=1, m=1.
